// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipelined bitwise logic unit.
//   S1 registers the operands and op; S2 registers the result, its flags
//   and a completed-handshake counter.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, op)
//   out_valid/out_ready result handshake (y, y_zero, y_ones, y_par)
//   txn_cnt             wrapping count of output handshakes
// Configuration macro: LOGIC_UNIT_PARITY_EN
//   defined   -> y_par is registered even parity of y
//   undefined -> y_par is tied to 0 and no parity logic is built
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic             y_par,
  output logic [CNT_W-1:0] txn_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_valid;
  logic             s2_free;
  logic             accept;
  logic             s1_adv;
  logic             out_hs;
  logic [WIDTH-1:0] res;

  // Handshake and advance conditions; in_ready never depends on in_valid.
  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign out_hs   = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // Bitwise operation on the S1 contents.
  always_comb begin
    res = '0;
    case (s1_op)
      3'd0:    res = ~s1_a;
      3'd1:    res = ~s1_b;
      3'd2:    res = s1_a & s1_b;
      3'd3:    res = ~(s1_a & s1_b);
      3'd4:    res = s1_a | s1_b;
      3'd5:    res = ~(s1_a | s1_b);
      3'd6:    res = s1_a ^ s1_b;
      3'd7:    res = s1_a ~^ s1_b;
      default: res = '0;
    endcase
  end

  // S1: load on accept (even while its old beat moves on), clear when drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= 3'd0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: capture the result when S1 advances, clear when drained; hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
      y_zero   <= 1'b0;
      y_ones   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      y        <= res;
      y_zero   <= ~|res;
      y_ones   <= &res;
    end else if (out_hs) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  // Parity travels with y into S2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (s1_adv) begin
      y_par <= ^res;
    end
  end
`else
  assign y_par = 1'b0;
`endif

  // Completed output handshakes, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (out_hs) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the completed-transaction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block can accept an operand beat this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 op  input  3  operation select, per REQ-015.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result beat.
REQ-012 y  output  WIDTH  registered result.
REQ-013 y_zero, y_ones  output  1 each  registered flags: y all zeros / y all ones.
REQ-014 y_par  output  1  registered even parity of y (XOR of all y bits); see REQ-031.
REQ-014a txn_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-015 op encoding, bitwise over WIDTH:
- 0: ~a
- 1: ~b
- 2: a&b
- 3: ~(a&b)
- 4: a|b
- 5: ~(a|b)
- 6: a^b
- 7: a~^b
REQ-016 Two register stages: S1 holds a, b, op and s1_valid; S2 holds y, the flags and s2_valid (drives out_valid).
REQ-017 Input accept when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-018 S2 advance condition: s2_free = !s2_valid || out_ready.
REQ-019 S1 advances into S2 when s1_valid && s2_free; the result is computed combinationally from the S1 contents and registered into S2.
REQ-020 in_ready = !s1_valid || s2_free; it is combinational from state and out_ready, with no dependence on in_valid.
REQ-021 Latency: a beat accepted at edge N appears on out_valid/y after edge N+1, provided no stall occurs.
REQ-022 Throughput: one beat per cycle while out_ready stays high.
REQ-023 While out_valid && !out_ready: y, the flags and out_valid hold stable; S1 holds; in_ready = !s1_valid.
REQ-024 Pipeline full (both stages valid, out_ready low): in_ready=0; no beat is dropped or duplicated.
REQ-025 Simultaneous accept and advance in the same cycle: S1 loads the new beat while its old beat moves to S2.
REQ-026 When S1 advances with no new accept, s1_valid clears; when S2 drains with no S1 advance, s2_valid clears.
REQ-027 txn_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
REQ-028 Beats exit in acceptance order; a/b/op of a held beat are never re-sampled.

Reset
REQ-029 When rst_n=0 at a rising edge, the following all become 0 at that edge:
- s1_valid, s2_valid (so out_valid=0)
- y, y_zero, y_ones, y_par
- txn_cnt
- all S1 registers
REQ-030 Reset mid-operation discards all in-flight beats; in_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-031 Macro LOGIC_UNIT_PARITY_EN gates the parity feature:
- defined: y_par is registered with y per REQ-014;
- undefined: the y_par port remains and is tied 0, and no parity logic is present.

Verification
REQ-032 WIDTH=8; a=8'hF0, b=8'h3C; op 0..7, one beat per cycle, out_ready=1 -> y sequence 0F, C3, 30, CF, FC, 03, CC, 33, each 2 edges after its accept.
REQ-033 a=8'hFF, b=8'hFF, op=2 -> y=FF, y_ones=1, y_zero=0, y_par=0; then op=6 -> y=00, y_zero=1.
REQ-034 Stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts; y holds the first result; raising out_ready delivers all 4 in order with no loss.
REQ-035 CNT_W=4; 17 output handshakes -> txn_cnt reads 1 (wrap at 16).
REQ-036 rst_n=0 for 1 cycle while both stages are valid -> next cycle out_valid=0, y=0, txn_cnt=0, in_ready=1; the pre-reset beats never appear.
REQ-037 Build without LOGIC_UNIT_PARITY_EN; a=8'h01, op=4, b=8'h00 -> y=01, y_par=0 (with the macro defined, y_par=1).
